sram_banked_arb: RTL and testbench

//  Parametrised multi-lane banked scratchpad for the SIMT core. LANES ports issue one batch per request.

---
 rtl/sram_banked_arb_if.sv | 32 +++
 rtl/sram_banked_arb.sv | 160 ++++++++++++++++
 tb/tb_sram_banked_arb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_banked_arb_if.sv
// sram_banked_arb_if
//   Request/response bundle between the SIMT LSU and the banked scratchpad.
//   master : LSU side. It drives req_valid, lane_en, we, addr and wd, and it
//            observes req_ready, rd, rd_valid and conflict_cnt.
//   slave  : scratchpad side, with the directions reversed.
//   addr and wd are packed per lane: lane i occupies [i*W +: W]. rd uses the
//   same packing.
interface sram_banked_arb_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [LANES-1:0]        lane_en;
  logic [LANES-1:0]        we;
  logic [LANES*ADDR_W-1:0] addr;
  logic [LANES*DATA_W-1:0] wd;
  logic [LANES*DATA_W-1:0] rd;
  logic                    rd_valid;
  logic [15:0]             conflict_cnt;

  modport master (
    output req_valid, lane_en, we, addr, wd,
    input  req_ready, rd, rd_valid, conflict_cnt
  );

  modport slave (
    input  req_valid, lane_en, we, addr, wd,
    output req_ready, rd, rd_valid, conflict_cnt
  );
endinterface

// File: rtl/sram_banked_arb.sv
// sram_banked_arb
//   Multi-lane banked scratchpad. Each request carries one batch of LANES
//   accesses. Word addresses are interleaved across BANKS single-port banks
//   using the low BSEL_W bits of the address. When several lanes hit the same
//   bank, their accesses are served one per cycle in lane order, lowest lane
//   first. req_ready stays low while a batch is being served.
// Ports
//   clk    : clock; all state changes on the rising edge
//   reset  : synchronous reset, active low (0 = reset)
//   bus    : sram_banked_arb_if.slave, which carries
//            req_valid/req_ready, lane_en, we, addr, wd, rd, rd_valid and
//            conflict_cnt
// Optional feature
//   SRAM_BCAST_EN : when a bank's leading pending lane is a read, every other
//                   pending read to the identical address in that bank is
//                   served in the same cycle.
module sram_banked_arb #(
  parameter int LANES  = 4,
  parameter int BANKS  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  sram_banked_arb_if.slave  bus
);
  localparam int BSEL_W = $clog2(BANKS);
  localparam int ROW_W  = ADDR_W - BSEL_W;
  localparam int DEPTH  = 1 << ROW_W;

  typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [LANES-1:0]        pending_reg, pending_next;
  logic [LANES-1:0]        we_reg;
  logic [LANES-1:0]        grant;
  logic [ADDR_W-1:0]       addr_reg [LANES];
  logic [DATA_W-1:0]       wd_reg   [LANES];
  logic [DATA_W-1:0]       rd_reg   [LANES];
  logic [DATA_W-1:0]       mem      [BANKS][DEPTH];
  logic [15:0]             conflict_cnt_reg;
  logic                    first_serve_reg;
  logic                    accept;
  logic [LANES*DATA_W-1:0] rd_flat;

  assign bus.req_ready    = (state_reg != SERVE);
  assign bus.rd_valid     = (state_reg == RESP);
  assign bus.conflict_cnt = conflict_cnt_reg;
  assign accept           = bus.req_valid && bus.req_ready;

  // Per-lane grant. A lane wins its bank when no lower pending lane maps to
  // the same bank. Because of that rule, a lower lane's write lands before a
  // higher lane's read, and the highest lane's write to an address lands last.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BSEL_W-1:0] my_bank;
      logic              lane_grant;
`ifdef SRAM_BCAST_EN
      logic              lead_found;
`endif
      assign my_bank = addr_reg[gi][BSEL_W-1:0];

      always_comb begin
        lane_grant = pending_reg[gi];
`ifdef SRAM_BCAST_EN
        lead_found = 1'b0;
        // Find the lowest pending lane in this bank. A read can share that
        // lane's cycle only when both accesses are reads of the same word.
        for (int j = 0; j < gi; j++) begin
          if (!lead_found && pending_reg[j] && addr_reg[j][BSEL_W-1:0] == my_bank) begin
            lead_found = 1'b1;
            lane_grant = pending_reg[gi] && !we_reg[j] && !we_reg[gi] &&
                         (addr_reg[j] == addr_reg[gi]);
          end
        end
`else
        for (int j = 0; j < gi; j++) begin
          if (pending_reg[j] && addr_reg[j][BSEL_W-1:0] == my_bank) begin
            lane_grant = 1'b0;
          end
        end
`endif
      end

      assign grant[gi] = lane_grant && (state_reg == SERVE);
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (accept) begin
          pending_next = bus.lane_en;
          state_next   = (bus.lane_en != '0) ? SERVE : RESP;
        end else begin
          state_next = IDLE;
        end
      end
      SERVE: begin
        pending_next = pending_reg & ~grant;
        if (pending_next == '0) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= IDLE;
      pending_reg      <= '0;
      conflict_cnt_reg <= '0;
      first_serve_reg  <= 1'b0;
      for (int l = 0; l < LANES; l++) rd_reg[l] <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (accept) first_serve_reg <= 1'b1;
      // Every serve cycle after the first one in a batch is a conflict cycle.
      if (state_reg == SERVE) begin
        first_serve_reg <= 1'b0;
        if (!first_serve_reg && conflict_cnt_reg != 16'hFFFF)
          conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
      end
      for (int l = 0; l < LANES; l++) begin
        if (grant[l] && !we_reg[l])
          rd_reg[l] <= mem[addr_reg[l][BSEL_W-1:0]][addr_reg[l][ADDR_W-1:BSEL_W]];
      end
    end
  end

  // The batch registers only change on accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg <= bus.we;
      for (int l = 0; l < LANES; l++) begin
        addr_reg[l] <= bus.addr[l*ADDR_W +: ADDR_W];
        wd_reg[l]   <= bus.wd[l*DATA_W +: DATA_W];
      end
    end
  end

  // Memory contents survive reset. Writes are suppressed on a reset edge, so
  // a batch that reset interrupts keeps only the writes it had already served.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        if (grant[l] && we_reg[l])
          mem[addr_reg[l][BSEL_W-1:0]][addr_reg[l][ADDR_W-1:BSEL_W]] <= wd_reg[l];
      end
    end
  end

  always_comb begin
    rd_flat = '0;
    for (int l = 0; l < LANES; l++) rd_flat[l*DATA_W +: DATA_W] = rd_reg[l];
  end
  assign bus.rd = rd_flat;
endmodule

// File: tb/tb_sram_banked_arb.sv
// Directed testbench for sram_banked_arb (LANES=4, BANKS=4, ADDR_W=14, DATA_W=32).
module tb_sram_banked_arb;
  localparam int LANES  = 4;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
`ifdef SRAM_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   exp_cc   = 0;

  sram_banked_arb_if #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_banked_arb #(.LANES(LANES), .BANKS(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_lane(input int l);
    logic [LANES*DATA_W-1:0] v;
    v = bus.rd;
    return v[l*DATA_W +: DATA_W];
  endfunction

  // Presents one batch and waits for rd_valid. The task returns in the
  // rd_valid cycle. edges is the number of clock edges from accept to rd_valid.
  task automatic run_batch(input logic [3:0] en, input logic [3:0] wr,
                           input logic [LANES*ADDR_W-1:0] a,
                           input logic [LANES*DATA_W-1:0] d,
                           output int edges, output bit ready_low);
    int wait_cnt;
    edges     = -1;
    ready_low = 1'b1;
    bus.req_valid = 1'b1;
    bus.lane_en   = en;
    bus.we        = wr;
    bus.addr      = a;
    bus.wd        = d;
    wait_cnt = 0;
    while (!bus.req_ready && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (wait_cnt >= 20) begin
      checks++; failures++;
      $display("FAIL accept_timeout: req_ready never high, required 1");
      return;
    end
    if (bus.rd_valid) begin
      edges = 0;
    end else begin
      for (int n = 1; n <= 20; n++) begin
        if (bus.req_ready) ready_low = 1'b0;
        @(posedge clk); #1;
        if (bus.rd_valid) begin
          edges = n;
          break;
        end
      end
      if (edges < 0) begin
        checks++; failures++;
        $display("FAIL rd_valid_timeout: no rd_valid within 20 cycles, required pulse");
      end
    end
    $display("batch en=%b we=%b edges=%0d cc=%0d rd=%h", en, wr, edges, bus.conflict_cnt, bus.rd);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.lane_en = '0; bus.we = '0; bus.addr = '0; bus.wd = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", bus.req_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b required 0", bus.rd_valid); end
    checks++; if (bus.conflict_cnt !== 16'd0) begin failures++; $display("FAIL reset_cc: got %0d required 0", bus.conflict_cnt); end
    checks++; if (bus.rd !== '0) begin failures++; $display("FAIL reset_rd: got %h required 0", bus.rd); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b required 1", bus.req_ready); end
  endtask

  task automatic test_no_conflict();
    int e; bit rl;
    run_batch(4'b1111, 4'b1111, {14'd2, 14'd3, 14'd5, 14'd0},
              {32'd5555, 32'd789, 32'd456, 32'd123}, e, rl);
    checks++; if (e !== 1) begin failures++; $display("FAIL nc_write_latency: got %0d required 1", e); end
    run_batch(4'b1111, 4'b0000, {14'd0, 14'd3, 14'd2, 14'd5}, '0, e, rl);
    checks++; if (e !== 1) begin failures++; $display("FAIL nc_read_latency: got %0d required 1", e); end
    checks++;
    if (bus.rd !== {32'd123, 32'd789, 32'd5555, 32'd456}) begin
      failures++; $display("FAIL nc_read_data: got %h required %h", bus.rd, {32'd123, 32'd789, 32'd5555, 32'd456});
    end
    checks++; if (bus.conflict_cnt !== 16'(exp_cc)) begin failures++; $display("FAIL nc_cc: got %0d required %0d", bus.conflict_cnt, exp_cc); end
  endtask

  task automatic test_full_conflict();
    int e; bit rl;
    run_batch(4'b1111, 4'b1111, {14'd16, 14'd12, 14'd8, 14'd4},
              {32'd160, 32'd120, 32'd80, 32'd40}, e, rl);
    exp_cc += 3;
    checks++; if (e !== 4) begin failures++; $display("FAIL fc_write_latency: got %0d required 4", e); end
    checks++; if (bus.conflict_cnt !== 16'(exp_cc)) begin failures++; $display("FAIL fc_write_cc: got %0d required %0d", bus.conflict_cnt, exp_cc); end
    run_batch(4'b1111, 4'b0000, {14'd12, 14'd8, 14'd4, 14'd0}, '0, e, rl);
    exp_cc += 3;
    checks++; if (e !== 4) begin failures++; $display("FAIL fc_read_latency: got %0d required 4", e); end
    checks++; if (rl !== 1'b1) begin failures++; $display("FAIL fc_ready_low: got %b required 1", rl); end
    checks++;
    if (bus.rd !== {32'd120, 32'd80, 32'd40, 32'd123}) begin
      failures++; $display("FAIL fc_read_data: got %h required %h", bus.rd, {32'd120, 32'd80, 32'd40, 32'd123});
    end
    checks++; if (bus.conflict_cnt !== 16'(exp_cc)) begin failures++; $display("FAIL fc_read_cc: got %0d required %0d", bus.conflict_cnt, exp_cc); end
  endtask

  task automatic test_same_addr_writes();
    int e; bit rl;
    run_batch(4'b1111, 4'b1111, {14'd7, 14'd7, 14'd7, 14'd7},
              {32'd4, 32'd3, 32'd2, 32'd1}, e, rl);
    exp_cc += 3;
    checks++; if (e !== 4) begin failures++; $display("FAIL sa_write_latency: got %0d required 4", e); end
    run_batch(4'b1111, 4'b0000, {14'd7, 14'd7, 14'd7, 14'd7}, '0, e, rl);
    exp_cc += BCAST ? 0 : 3;
    checks++; if (e !== (BCAST ? 1 : 4)) begin failures++; $display("FAIL sa_read_latency: got %0d required %0d", e, BCAST ? 1 : 4); end
    checks++;
    if (bus.rd !== {32'd4, 32'd4, 32'd4, 32'd4}) begin
      failures++; $display("FAIL sa_read_data: got %h required all lanes 4", bus.rd);
    end
    checks++; if (bus.conflict_cnt !== 16'(exp_cc)) begin failures++; $display("FAIL sa_cc: got %0d required %0d", bus.conflict_cnt, exp_cc); end
  endtask

  task automatic test_intra_batch_raw();
    int e; bit rl;
    // lane0 writes 77 to address 9 and lane1 reads address 9; lanes 2-3 inactive
    run_batch(4'b0011, 4'b0001, {14'd0, 14'd0, 14'd9, 14'd9},
              {32'd0, 32'd0, 32'd0, 32'd77}, e, rl);
    exp_cc += 1;
    checks++; if (e !== 2) begin failures++; $display("FAIL raw_latency: got %0d required 2", e); end
    checks++; if (rd_lane(1) !== 32'd77) begin failures++; $display("FAIL raw_rd1: got %0d required 77", rd_lane(1)); end
    checks++; if (rd_lane(2) !== 32'd4 || rd_lane(3) !== 32'd4) begin
      failures++; $display("FAIL inactive_unchanged: got %0d,%0d required 4,4", rd_lane(2), rd_lane(3));
    end
    // lane0 reads address 9 and lane1 writes 88 to it; lane0 must see the old value
    run_batch(4'b0011, 4'b0010, {14'd0, 14'd0, 14'd9, 14'd9},
              {32'd0, 32'd0, 32'd88, 32'd0}, e, rl);
    exp_cc += 1;
    checks++; if (rd_lane(0) !== 32'd77) begin failures++; $display("FAIL war_rd0: got %0d required 77", rd_lane(0)); end
    run_batch(4'b0100, 4'b0000, {14'd0, 14'd9, 14'd0, 14'd0}, '0, e, rl);
    checks++; if (rd_lane(2) !== 32'd88) begin failures++; $display("FAIL war_final: got %0d required 88", rd_lane(2)); end
    checks++; if (bus.conflict_cnt !== 16'(exp_cc)) begin failures++; $display("FAIL raw_cc: got %0d required %0d", bus.conflict_cnt, exp_cc); end
  endtask

  task automatic test_broadcast();
    int e; bit rl;
    run_batch(4'b1000, 4'b1000, {14'd6, 14'd0, 14'd0, 14'd0},
              {32'd600, 32'd0, 32'd0, 32'd0}, e, rl);
    run_batch(4'b1111, 4'b0000, {14'd6, 14'd6, 14'd6, 14'd6}, '0, e, rl);
    exp_cc += BCAST ? 0 : 3;
    checks++; if (e !== (BCAST ? 1 : 4)) begin failures++; $display("FAIL bc_latency: got %0d required %0d", e, BCAST ? 1 : 4); end
    checks++;
    if (bus.rd !== {32'd600, 32'd600, 32'd600, 32'd600}) begin
      failures++; $display("FAIL bc_data: got %h required all lanes 600", bus.rd);
    end
    checks++; if (bus.conflict_cnt !== 16'(exp_cc)) begin failures++; $display("FAIL bc_cc: got %0d required %0d", bus.conflict_cnt, exp_cc); end
  endtask

  task automatic test_empty_batch();
    int e; bit rl;
    run_batch(4'b0000, 4'b1111, {14'd6, 14'd6, 14'd6, 14'd6},
              {32'd9, 32'd9, 32'd9, 32'd9}, e, rl);
    checks++; if (e !== 0) begin failures++; $display("FAIL empty_latency: got %0d required 0", e); end
    checks++;
    if (bus.rd !== {32'd600, 32'd600, 32'd600, 32'd600}) begin
      failures++; $display("FAIL empty_rd_unchanged: got %h required all lanes 600", bus.rd);
    end
    checks++; if (bus.conflict_cnt !== 16'(exp_cc)) begin failures++; $display("FAIL empty_cc: got %0d required %0d", bus.conflict_cnt, exp_cc); end
  endtask

  task automatic test_back_to_back();
    int e; bit rl;
    run_batch(4'b0001, 4'b0000, {14'd0, 14'd0, 14'd0, 14'd0}, '0, e, rl);
    checks++; if (e !== 1 || rd_lane(0) !== 32'd123) begin failures++; $display("FAIL b2b_first: got edges=%0d rd0=%0d required 1,123", e, rd_lane(0)); end
    run_batch(4'b0010, 4'b0000, {14'd0, 14'd0, 14'd5, 14'd0}, '0, e, rl);
    checks++; if (e !== 1 || rd_lane(1) !== 32'd456) begin failures++; $display("FAIL b2b_second: got edges=%0d rd1=%0d required 1,456", e, rd_lane(1)); end
    @(posedge clk); #1;
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse_width: got %b required 0", bus.rd_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_ready: got %b required 1", bus.req_ready); end
  endtask

  task automatic test_reset_mid_batch();
    int e; bit rl; bit pulsed;
    run_batch(4'b1100, 4'b1100, {14'd32, 14'd28, 14'd0, 14'd0},
              {32'd6, 32'd5, 32'd0, 32'd0}, e, rl);
    checks++; if (e !== 2) begin failures++; $display("FAIL rm_preload_latency: got %0d required 2", e); end
    bus.req_valid = 1'b1; bus.lane_en = 4'b1111; bus.we = 4'b1111;
    bus.addr = {14'd32, 14'd28, 14'd24, 14'd20};
    bus.wd   = {32'd1003, 32'd1002, 32'd1001, 32'd1000};
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    pulsed = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.rd_valid) pulsed = 1'b1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    if (bus.rd_valid) pulsed = 1'b1;
    $display("reset mid-batch: ready=%b rd_valid=%b cc=%0d", bus.req_ready, bus.rd_valid, bus.conflict_cnt);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready: got %b required 1", bus.req_ready); end
    checks++; if (bus.rd !== '0) begin failures++; $display("FAIL rm_rd_cleared: got %h required 0", bus.rd); end
    checks++; if (bus.conflict_cnt !== 16'd0) begin failures++; $display("FAIL rm_cc_cleared: got %0d required 0", bus.conflict_cnt); end
    reset = 1'b1;
    exp_cc = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.rd_valid) pulsed = 1'b1;
    end
    checks++; if (pulsed !== 1'b0) begin failures++; $display("FAIL rm_no_pulse: got %b required 0", pulsed); end
    run_batch(4'b1111, 4'b0000, {14'd32, 14'd28, 14'd24, 14'd20}, '0, e, rl);
    exp_cc += 3;
    checks++;
    if (bus.rd !== {32'd6, 32'd5, 32'd1001, 32'd1000}) begin
      failures++; $display("FAIL rm_partial_writes: got %h required %h", bus.rd, {32'd6, 32'd5, 32'd1001, 32'd1000});
    end
    checks++; if (bus.conflict_cnt !== 16'(exp_cc)) begin failures++; $display("FAIL rm_cc_after: got %0d required %0d", bus.conflict_cnt, exp_cc); end
  endtask

  initial begin
    test_reset();
    test_no_conflict();
    test_full_conflict();
    test_same_addr_writes();
    test_intra_batch_raw();
    test_broadcast();
    test_empty_batch();
    test_back_to_back();
    test_reset_mid_batch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
